// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback stage: load funct3 codes and FSM state type.
package writeback_pkg;

   // Load funct3 encodings
   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

   // Writeback FSM state, one bit
   typedef enum logic {
      IDLE      = 1'b0,
      WAIT_LOAD = 1'b1
   } wb_state_t;

endpackage

// File: rtl/writeback_load_align.sv
// Load data alignment: selects byte/half from the read word and extends it.
module load_align
   import writeback_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed byte and halfword out of the word
   always_comb begin
      byte_sel = word[7:0];
      case (offset)
         2'd0:    byte_sel = word[7:0];
         2'd1:    byte_sel = word[15:8];
         2'd2:    byte_sel = word[23:16];
         default: byte_sel = word[31:24];
      endcase
      half_sel = offset[1] ? word[31:16] : word[15:0];
   end

   // Sign/zero extend according to the load type; unknown types pass the word
   always_comb begin
      result = word;
      case (funct3)
         LOAD_LB:  result = {{24{byte_sel[7]}}, byte_sel};
         LOAD_LBU: result = {24'h000000, byte_sel};
         LOAD_LH:  result = {{16{half_sel[15]}}, half_sel};
         LOAD_LHU: result = {16'h0000, half_sel};
         LOAD_LW:  result = word;
         default:  result = word;
      endcase
   end

endmodule

// File: rtl/writeback.sv
// Writeback stage: registers ALU results, waits for load data and aligns it.
module writeback
   import writeback_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] wb_result,
   input  logic        wb_alu_to_reg,
   input  logic        wb_mem_to_reg,
   input  logic [4:0]  wb_dest_reg_sel,
   input  logic [1:0]  wb_read_address,
   input  logic [2:0]  mem_alu_operation,
   input  logic        wb_branch,
   input  logic        wb_branch_nxt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        wb_we,
   output logic [4:0]  wb_waddr,
   output logic [31:0] wb_wdata,
   output logic        stall_read,
   output logic        wb_branch_i,
   output logic        wb_branch_nxt_i
);

   wb_state_t   state, state_n;
   logic [4:0]  ld_dest, ld_dest_n;
   logic [1:0]  ld_off, ld_off_n;
   logic [2:0]  ld_f3, ld_f3_n;
   logic        we_n;
   logic [4:0]  waddr_n;
   logic [31:0] wdata_n;
   logic        br_n, br_nxt_n;
   logic [31:0] aligned;

   load_align u_load_align (
      .word   (dmem_rdata),
      .offset (ld_off),
      .funct3 (ld_f3),
      .result (aligned)
   );

   // Next-state and next-output decode
   always_comb begin
      state_n   = state;
      ld_dest_n = ld_dest;
      ld_off_n  = ld_off;
      ld_f3_n   = ld_f3;
      we_n      = 1'b0;
      waddr_n   = wb_waddr;
      wdata_n   = wb_wdata;
      br_n      = wb_branch_i;
      br_nxt_n  = wb_branch_nxt_i;
      case (state)
         IDLE: begin
            br_n     = wb_branch;
            br_nxt_n = wb_branch_nxt;
            if (!wb_branch) begin
               if (wb_mem_to_reg) begin
                  state_n   = WAIT_LOAD;
                  ld_dest_n = wb_dest_reg_sel;
                  ld_off_n  = wb_read_address;
                  ld_f3_n   = mem_alu_operation;
               end else if (wb_alu_to_reg && (wb_dest_reg_sel != 5'd0)) begin
                  we_n    = 1'b1;
                  waddr_n = wb_dest_reg_sel;
                  wdata_n = wb_result;
               end
            end
         end
         WAIT_LOAD: begin
            if (dmem_rvalid) begin
               state_n = IDLE;
               if (ld_dest != 5'd0) begin
                  we_n    = 1'b1;
                  waddr_n = ld_dest;
                  wdata_n = aligned;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // State and output registers, asynchronously cleared
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         ld_dest         <= '0;
         ld_off          <= '0;
         ld_f3           <= '0;
         wb_we           <= 1'b0;
         wb_waddr        <= '0;
         wb_wdata        <= '0;
         wb_branch_i     <= 1'b0;
         wb_branch_nxt_i <= 1'b0;
      end else begin
         state           <= state_n;
         ld_dest         <= ld_dest_n;
         ld_off          <= ld_off_n;
         ld_f3           <= ld_f3_n;
         wb_we           <= we_n;
         wb_waddr        <= waddr_n;
         wb_wdata        <= wdata_n;
         wb_branch_i     <= br_n;
         wb_branch_nxt_i <= br_nxt_n;
      end
   end

   assign stall_read = (state == WAIT_LOAD);

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed table, corner sequences, random.
module tb_writeback;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] wb_result;
   logic        wb_alu_to_reg, wb_mem_to_reg;
   logic [4:0]  wb_dest_reg_sel;
   logic [1:0]  wb_read_address;
   logic [2:0]  mem_alu_operation;
   logic        wb_branch, wb_branch_nxt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        wb_we;
   logic [4:0]  wb_waddr;
   logic [31:0] wb_wdata;
   logic        stall_read, wb_branch_i, wb_branch_nxt_i;

   int n_tests = 0;
   int n_fail  = 0;

   writeback dut (
      .clk               (clk),
      .reset             (reset),
      .wb_result         (wb_result),
      .wb_alu_to_reg     (wb_alu_to_reg),
      .wb_mem_to_reg     (wb_mem_to_reg),
      .wb_dest_reg_sel   (wb_dest_reg_sel),
      .wb_read_address   (wb_read_address),
      .mem_alu_operation (mem_alu_operation),
      .wb_branch         (wb_branch),
      .wb_branch_nxt     (wb_branch_nxt),
      .dmem_rvalid       (dmem_rvalid),
      .dmem_rdata        (dmem_rdata),
      .wb_we             (wb_we),
      .wb_waddr          (wb_waddr),
      .wb_wdata          (wb_wdata),
      .stall_read        (stall_read),
      .wb_branch_i       (wb_branch_i),
      .wb_branch_nxt_i   (wb_branch_nxt_i)
   );

   always #5 clk = ~clk;

   // Reference model state
   logic        m_busy, m_we, m_bi, m_bni;
   logic [4:0]  m_dest, m_waddr;
   logic [1:0]  m_off;
   logic [2:0]  m_f3;
   logic [31:0] m_wdata;

   function automatic logic [31:0] ref_align(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] f3);
      logic [31:0] b, h;
      b = w >> (8 * off);
      h = w >> (16 * off[1]);
      case (f3)
         3'd0:    return 32'($signed(b[7:0]));
         3'd4:    return {24'h0, b[7:0]};
         3'd1:    return 32'($signed(h[15:0]));
         3'd5:    return {16'h0, h[15:0]};
         default: return w;
      endcase
   endfunction

   task automatic model_reset();
      m_busy = 0; m_we = 0; m_bi = 0; m_bni = 0;
      m_dest = 0; m_waddr = 0; m_off = 0; m_f3 = 0; m_wdata = 0;
   endtask

   // Apply the architectural rules to the inputs present at the coming edge
   task automatic model_step();
      m_we = 0;
      if (!m_busy) begin
         m_bi  = wb_branch;
         m_bni = wb_branch_nxt;
         if (!wb_branch && wb_mem_to_reg) begin
            m_busy = 1; m_dest = wb_dest_reg_sel; m_off = wb_read_address; m_f3 = mem_alu_operation;
         end else if (!wb_branch && wb_alu_to_reg && wb_dest_reg_sel != 0) begin
            m_we = 1; m_waddr = wb_dest_reg_sel; m_wdata = wb_result;
         end
      end else if (dmem_rvalid) begin
         m_busy = 0;
         if (m_dest != 0) begin
            m_we = 1; m_waddr = m_dest; m_wdata = ref_align(dmem_rdata, m_off, m_f3);
         end
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      check("we",        32'(wb_we),           32'(m_we));
      check("waddr",     32'(wb_waddr),        32'(m_waddr));
      check("wdata",     wb_wdata,             m_wdata);
      check("stall",     32'(stall_read),      32'(m_busy));
      check("branch_i",  32'(wb_branch_i),     32'(m_bi));
      check("branchn_i", 32'(wb_branch_nxt_i), 32'(m_bni));
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic clear_inputs();
      wb_alu_to_reg = 0; wb_mem_to_reg = 0; wb_branch = 0; wb_branch_nxt = 0;
      wb_dest_reg_sel = 0; wb_result = 0; wb_read_address = 0; mem_alu_operation = 0;
      dmem_rvalid = 0; dmem_rdata = 0;
   endtask

   typedef struct {
      logic        alu, mem, br;
      logic [4:0]  dest;
      logic [31:0] res;
      logic [2:0]  f3;
      logic [1:0]  off;
      logic [31:0] rdata;
      int          lat;
      logic        exp_we;
      logic [31:0] exp_wdata;
   } vec_t;

   vec_t tbl[16];

   task automatic run_vec(input vec_t v, input int idx);
      string tag;
      tag = $sformatf("vec%0d", idx);
      wb_alu_to_reg = v.alu; wb_mem_to_reg = v.mem; wb_branch = v.br;
      wb_dest_reg_sel = v.dest; wb_result = v.res; mem_alu_operation = v.f3;
      wb_read_address = v.off; dmem_rvalid = 0;
      tick();
      check({tag, "_stall"}, 32'(stall_read), 32'(v.mem && !v.br));
      if (v.mem && !v.br) begin
         // noise that a stalled stage must ignore
         wb_alu_to_reg = 1; wb_dest_reg_sel = 5'd31; wb_result = 32'hBAD0BAD0; wb_branch_nxt = 1;
      end else clear_inputs();
      if (v.mem) begin
         repeat (v.lat) tick();
         dmem_rvalid = 1; dmem_rdata = v.rdata;
         tick();
      end
      clear_inputs();
      check({tag, "_we"}, 32'(wb_we), 32'(v.exp_we));
      if (v.exp_we) begin
         check({tag, "_waddr"}, 32'(wb_waddr), 32'(v.dest));
         check({tag, "_wdata"}, wb_wdata, v.exp_wdata);
      end
   endtask

   initial begin
      //          alu   mem   br    dest   res            f3    off   rdata          lat exp_we exp_wdata
      tbl[0]  = '{1'b1, 1'b0, 1'b0, 5'd5,  32'h00000014, 3'd0, 2'd0, 32'h0,         0, 1'b1, 32'h00000014};
      tbl[1]  = '{1'b1, 1'b0, 1'b0, 5'd0,  32'h0000DEAD, 3'd0, 2'd0, 32'h0,         0, 1'b0, 32'h0};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, 5'd3,  32'h0,        3'd0, 2'd2, 32'h12A45678,  2, 1'b1, 32'hFFFFFFA4};
      tbl[3]  = '{1'b0, 1'b1, 1'b0, 5'd3,  32'h0,        3'd4, 2'd2, 32'h12A45678,  0, 1'b1, 32'h000000A4};
      tbl[4]  = '{1'b0, 1'b1, 1'b0, 5'd6,  32'h0,        3'd0, 2'd0, 32'h0000007F,  1, 1'b1, 32'h0000007F};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 5'd6,  32'h0,        3'd0, 2'd3, 32'h80000000,  0, 1'b1, 32'hFFFFFF80};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 5'd8,  32'h0,        3'd5, 2'd2, 32'h8001FFFF,  0, 1'b1, 32'h00008001};
      tbl[7]  = '{1'b0, 1'b1, 1'b0, 5'd8,  32'h0,        3'd1, 2'd2, 32'h8001FFFF,  0, 1'b1, 32'hFFFF8001};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 5'd10, 32'h0,        3'd1, 2'd0, 32'h12347FFF,  0, 1'b1, 32'h00007FFF};
      tbl[9]  = '{1'b0, 1'b1, 1'b0, 5'd11, 32'h0,        3'd2, 2'd1, 32'hCAFEBABE,  0, 1'b1, 32'hCAFEBABE};
      tbl[10] = '{1'b0, 1'b1, 1'b0, 5'd12, 32'h0,        3'd3, 2'd3, 32'h01234567,  0, 1'b1, 32'h01234567};
      tbl[11] = '{1'b0, 1'b1, 1'b0, 5'd13, 32'h0,        3'd6, 2'd1, 32'h89ABCDEF,  0, 1'b1, 32'h89ABCDEF};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 5'd14, 32'h0,        3'd2, 2'd0, 32'h55555555,  0, 1'b0, 32'h0};
      tbl[13] = '{1'b1, 1'b0, 1'b1, 5'd7,  32'h77777777, 3'd0, 2'd0, 32'h0,         0, 1'b0, 32'h0};
      tbl[14] = '{1'b1, 1'b1, 1'b0, 5'd9,  32'h00005555, 3'd4, 2'd1, 32'h0000AB00,  0, 1'b1, 32'h000000AB};
      tbl[15] = '{1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        3'd2, 2'd0, 32'hFFFFFFFF,  1, 1'b0, 32'h0};

      clear_inputs();
      reset = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      reset = 1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) run_vec(tbl[i], i);

      // Branch flags are registered in IDLE and held during WAIT_LOAD
      wb_branch_nxt = 1; wb_mem_to_reg = 1; wb_dest_reg_sel = 5'd2;
      tick();
      wb_branch_nxt = 0; wb_mem_to_reg = 0;
      tick();
      check("bnxt_hold", 32'(wb_branch_nxt_i), 32'd1);
      dmem_rvalid = 1; dmem_rdata = 32'h00000042;
      tick();
      dmem_rvalid = 0;
      tick();
      check("bnxt_idle", 32'(wb_branch_nxt_i), 32'd0);

      // Reset mid-WAIT_LOAD abandons the load immediately
      wb_mem_to_reg = 1; wb_dest_reg_sel = 5'd4; mem_alu_operation = 3'd2;
      tick();
      clear_inputs();
      check("wait_entered", 32'(stall_read), 32'd1);
      #2 reset = 0;
      #1;
      model_reset();
      check("rst_stall", 32'(stall_read), 32'd0);
      check("rst_we",    32'(wb_we),      32'd0);
      check("rst_waddr", 32'(wb_waddr),   32'd0);
      check("rst_wdata", wb_wdata,        32'd0);
      @(negedge clk);
      reset = 1;
      dmem_rvalid = 1; dmem_rdata = 32'h12345678;
      tick();
      check("rst_no_write", 32'(wb_we), 32'd0);
      clear_inputs();

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         wb_alu_to_reg     = 1'($urandom_range(0, 1));
         wb_mem_to_reg     = ($urandom_range(0, 3) == 0);
         wb_branch         = ($urandom_range(0, 3) == 0);
         wb_branch_nxt     = 1'($urandom_range(0, 1));
         wb_dest_reg_sel   = 5'($urandom_range(0, 31));
         wb_result         = $urandom;
         wb_read_address   = 2'($urandom_range(0, 3));
         mem_alu_operation = 3'($urandom_range(0, 7));
         dmem_rvalid       = ($urandom_range(0, 2) == 0);
         dmem_rdata        = $urandom;
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 clk  in  1  single pipeline clock; all state updates on its rising edge.
REQ-002 reset  in  1  asynchronous, active-low; 0 clears all state immediately, independent of clk.
REQ-003 wb_result  in  32  EX result: ALU value or load effective address.
REQ-004 wb_alu_to_reg  in  1  EX instruction writes wb_result to the register file.
REQ-005 wb_mem_to_reg  in  1  EX instruction is a load.
REQ-006 wb_dest_reg_sel  in  5  destination register index.
REQ-007 wb_read_address  in  2  load byte offset within the word.
REQ-008 mem_alu_operation  in  3  load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-009 wb_branch  in  1  EX instruction is squashed (flush); it must have no architectural effect.
REQ-010 wb_branch_nxt  in  1  flush pending for the following instruction.
REQ-011 dmem_rvalid  in  1  data memory read data valid this cycle.
REQ-012 dmem_rdata  in  32  data memory read word.
REQ-013 wb_we  out  1  register file write enable.
REQ-014 wb_waddr  out  5  register file write index.
REQ-015 wb_wdata  out  32  register file write data.
REQ-016 stall_read  out  1  holds execute stage while a load is outstanding.
REQ-017 wb_branch_i  out  1  registered wb_branch returned to execute.
REQ-018 wb_branch_nxt_i  out  1  registered wb_branch_nxt returned to execute.

Function
REQ-019 FSM states: IDLE, WAIT_LOAD; encoding is 1 bit.
REQ-020 IDLE, inputs consumed every cycle; WAIT_LOAD, inputs ignored (execute is stalled).
REQ-021 IDLE, wb_branch=0, wb_alu_to_reg=1 -> next cycle wb_we=1, wb_waddr=wb_dest_reg_sel, wb_wdata=wb_result (latency 1).
REQ-022 IDLE, wb_branch=0, wb_mem_to_reg=1 -> capture dest, offset, funct3; go to WAIT_LOAD; takes priority over wb_alu_to_reg if both set.
REQ-023 wb_branch=1 in IDLE -> no write, no state change.
REQ-024 stall_read = (state==WAIT_LOAD), decoded from the state register, no combinational path from inputs.
REQ-025 WAIT_LOAD, dmem_rvalid=1 -> next cycle wb_we=1 with aligned data, state=IDLE; dmem_rvalid in IDLE is ignored.
REQ-026 Alignment: LB/LBU select byte offset[1:0]; LH/LHU select half offset[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW and any other funct3 pass the word unchanged.
REQ-027 Destination index 0 -> wb_we forced 0 for both ALU and load paths.
REQ-028 wb_we is a single-cycle pulse; wb_waddr/wb_wdata hold their last values when wb_we=0.
REQ-029 wb_branch_i/wb_branch_nxt_i register wb_branch/wb_branch_nxt each cycle in IDLE and hold in WAIT_LOAD.
REQ-030 WAIT_LOAD has no timeout; it is left only by dmem_rvalid or reset.

Reset
REQ-031 reset=0 -> state=IDLE, wb_we=0, wb_waddr=0, wb_wdata=0, stall_read=0, wb_branch_i=0, wb_branch_nxt_i=0, captured load fields=0.
REQ-032 reset during WAIT_LOAD abandons the load; a later dmem_rvalid causes no write.

Structure
REQ-033 Shared package holds the funct3 load codes and the FSM state type.
REQ-034 One combinational sub-module, load_align (word, offset, funct3 -> 32-bit result), is instantiated once.

Verification
REQ-035 ALU: wb_alu_to_reg=1, dest=5, result=0x00000014 -> next cycle wb_we=1, waddr=5, wdata=0x00000014.
REQ-036 LB: offset=2, rdata=0x12A45678, rvalid 3 cycles after acceptance -> stall_read=1 for 3 cycles, then wb_wdata=0xFFFFFFA4 to dest.
REQ-037 LHU: offset=2, rdata=0x8001FFFF -> wb_wdata=0x00008001; LH with the same inputs -> 0xFFFF8001.
REQ-038 Squash: wb_branch=1 with a load or ALU op -> no wb_we, stall_read stays 0.
REQ-039 Dest x0: ALU op dest=0 -> wb_we=0; reset=0 asserted mid-WAIT_LOAD -> stall_read=0 immediately and a following rvalid writes nothing.
